// File: rtl/data_register_pkg.sv
// Shared matmul datapath constants used by the storage registers.
package data_register_pkg;

  localparam int unsigned MM_DATA_WIDTH = 8;

endpackage

// File: rtl/data_register.sv
// Single-word holding register with write enable and asynchronous clear.
// Used for the operand, partial-sum and address registers of the matmul datapath.
module data_register
  import data_register_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] word_q;

  // Reset wins over we, so a write that coincides with reset is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
    end else if (we) begin
      word_q <= data_in;
    end
  end

  assign data_out = word_q;

endmodule

// File: tb/tb_data_register.sv
// Self-checking bench for data_register: directed table, async-reset sequences
// and randomized traffic against a simple behavioural storage model.
module tb_data_register;

  logic        clk;
  logic        rst;
  logic        we8;
  logic [7:0]  din8;
  logic [7:0]  dout8;
  logic        we16;
  logic [15:0] din16;
  logic [15:0] dout16;

  int unsigned n_checks;
  int unsigned n_errors;

  data_register u_dut8 (
    .clk      (clk),
    .rst      (rst),
    .we       (we8),
    .data_in  (din8),
    .data_out (dout8)
  );

  data_register #(.DATA_WIDTH(16)) u_dut16 (
    .clk      (clk),
    .rst      (rst),
    .we       (we16),
    .data_in  (din16),
    .data_out (dout16)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       we;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: the register simply remembers the last word written
  // since the last reset.
  logic [7:0]  model8;
  logic [15:0] model16;

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Power-up: reset with a conflicting write pending.
    rst = 1'b1; we8 = 1'b1; din8 = 8'hFF; we16 = 1'b1; din16 = 16'hFFFF;
    #1;
    check("reset_immediate8", {8'h00, dout8}, 16'h0000);
    check("reset_immediate16", dout16, 16'h0000);
    @(posedge clk); #2;
    check("reset_held8", {8'h00, dout8}, 16'h0000);
    check("reset_held16", dout16, 16'h0000);

    // Directed table, one clock edge per row.
    vecs.push_back('{1'b0, 1'b1, 8'h01, 8'h01});
    vecs.push_back('{1'b0, 1'b0, 8'h02, 8'h01});
    vecs.push_back('{1'b0, 1'b0, 8'h05, 8'h01});
    vecs.push_back('{1'b0, 1'b1, 8'h07, 8'h07});
    vecs.push_back('{1'b0, 1'b1, 8'hFF, 8'hFF});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 8'hFF});
    vecs.push_back('{1'b1, 1'b1, 8'h3C, 8'h00});
    vecs.push_back('{1'b0, 1'b0, 8'h3C, 8'h00});
    vecs.push_back('{1'b0, 1'b1, 8'h80, 8'h80});
    vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h00});
    we16 = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; we8 = vecs[i].we; din8 = vecs[i].din;
      @(posedge clk); #2;
      check($sformatf("table[%0d]", i), {8'h00, dout8}, {8'h00, vecs[i].exp});
    end

    // Write 7, then change data_in between edges: output must not follow.
    @(negedge clk);
    we8 = 1'b1; din8 = 8'h07;
    @(posedge clk); #2;
    check("write7", {8'h00, dout8}, 16'h0007);
    #3 din8 = 8'h09;
    #3 check("no_passthrough", {8'h00, dout8}, 16'h0007);

    // Reset asserted mid-cycle while a write is requested.
    @(posedge clk); #5;
    check("pre_reset9", {8'h00, dout8}, 16'h0009);
    rst = 1'b1; we8 = 1'b1; din8 = 8'hAA;
    #1 check("midcycle_reset", {8'h00, dout8}, 16'h0000);
    @(posedge clk); #2;
    check("reset_beats_we", {8'h00, dout8}, 16'h0000);
    @(negedge clk);
    rst = 1'b0; we8 = 1'b0;
    #2 check("reset_release_no_edge", {8'h00, dout8}, 16'h0000);
    @(posedge clk); #2;
    check("hold_after_release", {8'h00, dout8}, 16'h0000);

    // 16-bit instance: load then hold.
    @(negedge clk);
    we16 = 1'b1; din16 = 16'hBEEF;
    @(posedge clk); #2;
    check("wide_write", dout16, 16'hBEEF);
    @(negedge clk);
    we16 = 1'b0; din16 = 16'h1234;
    @(posedge clk); #2;
    check("wide_hold", dout16, 16'hBEEF);

    // Randomized traffic on both instances against the model.
    @(negedge clk);
    rst = 1'b1;
    #1;
    model8 = '0; model16 = '0;
    check("rand_reset8", {8'h00, dout8}, 16'h0000);
    check("rand_reset16", dout16, 16'h0000);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 19) == 0);
      we8   = $urandom_range(0, 1) == 1;
      we16  = $urandom_range(0, 1) == 1;
      din8  = 8'($urandom);
      din16 = 16'($urandom);
      #1;
      if (rst) begin
        model8 = '0; model16 = '0;
        check("rand_async8", {8'h00, dout8}, 16'h0000);
        check("rand_async16", dout16, 16'h0000);
      end
      @(posedge clk);
      if (!rst) begin
        if (we8)  model8  = din8;
        if (we16) model16 = din16;
      end
      #2;
      check("rand8", {8'h00, dout8}, {8'h00, model8});
      check("rand16", dout16, model16);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
